uart_frame_deframer: RTL

//  Parametrised UART frame receiver between the byte-level UART RX and game logic. Hunts a

---
 rtl/uart_frame_deframer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_frame_deframer.sv
// Purpose : hunts a preamble, collects a fixed-length payload, checks sum/timeout, publishes frames atomically.
// Latency : frame_valid / frame_err pulse one cycle after the rx_done of the last (or checksum) byte.
// Backpr. : none; a byte is accepted on every rx_done, back-to-back included, nothing is ever stalled.
module uart_frame_deframer #(
   parameter int unsigned PREAMBLE_LEN   = 4,
   parameter logic [7:0]  PREAMBLE_BYTE  = 8'hFF,
   parameter int unsigned PAYLOAD_BYTES  = 10,
   parameter int unsigned CHECKSUM_EN    = 1,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rx_done,
   input  logic [7:0]                   rx_byte,
   output logic [8*PAYLOAD_BYTES-1:0]   payload,
   output logic                         frame_valid,
   output logic                         frame_err,
   output logic                         busy,
   output logic [15:0]                  frames_ok,
   output logic [15:0]                  frames_bad
);

   localparam int PW = $clog2(PREAMBLE_LEN + 1);
   localparam int BW = $clog2(PAYLOAD_BYTES + 1);
   localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

   localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_LEN - 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(PAYLOAD_BYTES - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_HUNT,
      S_PAYLOAD,
      S_CHECK
   } state_t;

   state_t                       state;
   logic [PW-1:0]                pre_cnt;
   logic [BW-1:0]                byte_idx;
   logic [7:0]                   sum;
   logic [IW-1:0]                idle;
   logic [8*PAYLOAD_BYTES-1:0]   shadow;
   logic [8*PAYLOAD_BYTES-1:0]   shadow_wr;
   logic                         timeout_hit;
   logic [15:0]                  ok_next;
   logic [15:0]                  bad_next;

   // Shadow buffer with the incoming byte merged in, so the last byte can commit on its own edge.
   always_comb begin
      shadow_wr = shadow;
      for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
         if (byte_idx == BW'(i)) shadow_wr[8*i +: 8] = rx_byte;
      end
   end

   // A byte arriving on the expiring cycle takes priority over the timeout.
   assign timeout_hit = TO_EN && !rx_done && (idle == IDLE_LAST);
   assign ok_next     = (frames_ok  == 16'hFFFF) ? frames_ok  : frames_ok  + 16'd1;
   assign bad_next    = (frames_bad == 16'hFFFF) ? frames_bad : frames_bad + 16'd1;

   // Frame state machine; every output is a register updated here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_HUNT;
         pre_cnt     <= '0;
         byte_idx    <= '0;
         sum         <= '0;
         idle        <= '0;
         shadow      <= '0;
         payload     <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
         frames_ok   <= '0;
         frames_bad  <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            S_HUNT: begin
               idle <= '0;
               if (rx_done) begin
                  if (rx_byte == PREAMBLE_BYTE) begin
                     if (pre_cnt == PRE_LAST) begin
                        pre_cnt  <= '0;
                        byte_idx <= '0;
                        sum      <= '0;
                        busy     <= 1'b1;
                        state    <= S_PAYLOAD;
                     end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                     end
                  end else begin
                     pre_cnt <= '0;
                  end
               end
            end
            S_PAYLOAD: begin
               if (rx_done) begin
                  // Preamble-valued bytes are plain data here.
                  idle     <= '0;
                  shadow   <= shadow_wr;
                  sum      <= sum + rx_byte;
                  byte_idx <= byte_idx + 1'b1;
                  if (byte_idx == IDX_LAST) begin
                     if (CHECKSUM_EN != 0) begin
                        state <= S_CHECK;
                     end else begin
                        payload     <= shadow_wr;
                        frame_valid <= 1'b1;
                        frames_ok   <= ok_next;
                        busy        <= 1'b0;
                        state       <= S_HUNT;
                     end
                  end
               end else if (timeout_hit) begin
                  frame_err  <= 1'b1;
                  frames_bad <= bad_next;
                  busy       <= 1'b0;
                  state      <= S_HUNT;
               end else if (TO_EN) begin
                  idle <= idle + 1'b1;
               end
            end
            S_CHECK: begin
               if (rx_done) begin
                  idle  <= '0;
                  busy  <= 1'b0;
                  state <= S_HUNT;
                  if (rx_byte == sum) begin
                     payload     <= shadow;
                     frame_valid <= 1'b1;
                     frames_ok   <= ok_next;
                  end else begin
                     frame_err  <= 1'b1;
                     frames_bad <= bad_next;
                  end
               end else if (timeout_hit) begin
                  frame_err  <= 1'b1;
                  frames_bad <= bad_next;
                  busy       <= 1'b0;
                  state      <= S_HUNT;
               end else if (TO_EN) begin
                  idle <= idle + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_HUNT;
            end
         endcase
      end
   end

endmodule
